// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - two-port round-robin write sequencer for the HD44780 LCD bus
//
// Ports:
//   iCLK, iRST          system clock (CLOCK_50), synchronous active-high reset
//   iREQ0/1             level write requests from the two requesters
//   iRS0/1, iDATA0/1    register select (0 = command, 1 = data) and byte per requester
//   oACK0/1             one-cycle pulse when the matching request is captured
//   oBUSY               high whenever the sequencer is not idle
//   LCD_DATA, LCD_RS    latched byte and register select driven to the panel
//   LCD_RW              tied low (write only)
//   LCD_EN              enable strobe
module lcd_bus_arbiter #(
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 16,
    parameter int HOLD_CYC      = 2,
    parameter int WAIT_CYC      = 2000,
    parameter int LONG_WAIT_CYC = 82000,
    parameter int CNT_W         = 17
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ0,
    input  logic       iREQ1,
    input  logic       iRS0,
    input  logic       iRS1,
    input  logic [7:0] iDATA0,
    input  logic [7:0] iDATA1,
    output logic       oACK0,
    output logic       oACK1,
    output logic       oBUSY,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    // The timer holds "cycles remaining minus one", so each phase is loaded
    // with its length minus one and advances when the timer reads zero.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic             last_grant, last_n;
    logic             rs_n;
    logic [7:0]       data_n;
    logic             ack0_n, ack1_n;
    logic             grant0, grant1;
    logic             is_long;

    // Port 0 wins when alone, or on a tie when port 1 had the last grant.
    assign grant0 = iREQ0 && (!iREQ1 || last_grant);
    assign grant1 = iREQ1 && !grant0;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign is_long = !LCD_RS && ((LCD_DATA == 8'h01) || (LCD_DATA == 8'h02) || (LCD_DATA == 8'h03));

    always_comb begin
        state_n = state;
        timer_n = timer;
        last_n  = last_grant;
        rs_n    = LCD_RS;
        data_n  = LCD_DATA;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant0) begin
                    state_n = S_SETUP;
                    timer_n = SETUP_LD;
                    last_n  = 1'b0;
                    rs_n    = iRS0;
                    data_n  = iDATA0;
                    ack0_n  = 1'b1;
                end else if (grant1) begin
                    state_n = S_SETUP;
                    timer_n = SETUP_LD;
                    last_n  = 1'b1;
                    rs_n    = iRS1;
                    data_n  = iDATA1;
                    ack1_n  = 1'b1;
                end
            end
            S_SETUP: begin
                if (timer == '0) begin
                    state_n = S_PULSE;
                    timer_n = EN_LD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_PULSE: begin
                if (timer == '0) begin
                    state_n = S_HOLD;
                    timer_n = HOLD_LD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_HOLD: begin
                if (timer == '0) begin
                    state_n = S_WAIT;
                    timer_n = is_long ? LONG_LD : WAIT_LD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_WAIT: begin
                if (timer == '0) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= S_IDLE;
            timer      <= '0;
            last_grant <= 1'b1;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            LCD_EN     <= 1'b0;
            oACK0      <= 1'b0;
            oACK1      <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            last_grant <= last_n;
            LCD_RS     <= rs_n;
            LCD_DATA   <= data_n;
            // Strobe and busy are registered from the next state so they line up with it.
            LCD_EN     <= (state_n == S_PULSE);
            oACK0      <= ack0_n;
            oACK1      <= ack1_n;
            oBUSY      <= (state_n != S_IDLE);
        end
    end

    assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - scoreboard bench for lcd_bus_arbiter
module tb_lcd_bus_arbiter;

    localparam int SETUP_C   = 2;
    localparam int EN_C      = 16;
    localparam int HOLD_C    = 2;
    localparam int WAIT_C    = 2000;
    localparam int LONG_C    = 5000;
    localparam int SHORT_PER = 1 + SETUP_C + EN_C + HOLD_C + WAIT_C;
    localparam int LONG_PER  = 1 + SETUP_C + EN_C + HOLD_C + LONG_C;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iREQ0 = 1'b0, iREQ1 = 1'b0;
    logic       iRS0 = 1'b0, iRS1 = 1'b0;
    logic [7:0] iDATA0 = 8'h00, iDATA1 = 8'h00;
    logic       oACK0, oACK1, oBUSY;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN;

    lcd_bus_arbiter #(
        .SETUP_CYC(SETUP_C), .EN_CYC(EN_C), .HOLD_CYC(HOLD_C),
        .WAIT_CYC(WAIT_C), .LONG_WAIT_CYC(LONG_C), .CNT_W(17)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iREQ0(iREQ0), .iREQ1(iREQ1), .iRS0(iRS0), .iRS1(iRS1),
        .iDATA0(iDATA0), .iDATA1(iDATA1),
        .oACK0(oACK0), .oACK1(oACK1), .oBUSY(oBUSY),
        .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
    );

    always #10 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int         port;
        logic       rs;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input int port, input logic rs, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.rs   = rs;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every ack and watches bus invariants.
    bit         mon_en = 1'b0;
    bit         mon_valid = 1'b0;
    logic       prev_rs;
    logic [7:0] prev_data;
    exp_t       mon_e;
    int         mon_port;
    bit         mon_ack;
    bit         mon_chg;

    always @(posedge iCLK) begin
        #1;
        if (mon_en) begin
            mon_ack = oACK0 || oACK1;
            total++;
            if (oACK0 && oACK1) $display("FAIL dual_ack cyc=%0d ack0=%b ack1=%b expected at most one", cyc, oACK0, oACK1);
            else passed++;
            total++;
            if (LCD_RW !== 1'b0) $display("FAIL lcd_rw cyc=%0d got=%b exp=0", cyc, LCD_RW);
            else passed++;
            if (mon_ack) begin
                mon_port = oACK0 ? 0 : 1;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL spurious_ack cyc=%0d port=%0d expected no ack", cyc, mon_port);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_port !== mon_e.port || LCD_RS !== mon_e.rs || LCD_DATA !== mon_e.data)
                        $display("FAIL ack_content cyc=%0d got port=%0d rs=%b data=%h exp port=%0d rs=%b data=%h",
                                 cyc, mon_port, LCD_RS, LCD_DATA, mon_e.port, mon_e.rs, mon_e.data);
                    else passed++;
                end
            end
            if (mon_valid) begin
                mon_chg = (LCD_RS !== prev_rs) || (LCD_DATA !== prev_data);
                total++;
                if (mon_chg && (!(mon_ack || iRST) || LCD_EN))
                    $display("FAIL bus_stable cyc=%0d got rs=%b data=%h prev rs=%b data=%h en=%b",
                             cyc, LCD_RS, LCD_DATA, prev_rs, prev_data, LCD_EN);
                else passed++;
            end
            prev_rs   = LCD_RS;
            prev_data = LCD_DATA;
            mon_valid = 1'b1;
        end
    end

    task automatic wait_ack(input int budget, output int port, output int at);
        int n;
        port = -1;
        at   = -1;
        n    = 0;
        while (port < 0 && n < budget) begin
            @(negedge iCLK);
            n++;
            if (oACK0) begin
                port = 0;
                at   = cyc;
            end else if (oACK1) begin
                port = 1;
                at   = cyc;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge iCLK);
            n++;
            if (!oBUSY) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int c, p, t;
        bit ok;
        iREQ1  = 1'b1;
        iRS1   = 1'b1;
        iDATA1 = 8'h55;
        repeat (4) begin
            @(negedge iCLK);
            total++;
            if (oACK1 !== 1'b0 || oACK0 !== 1'b0) $display("FAIL ack_in_reset got ack0=%b ack1=%b exp 0", oACK0, oACK1);
            else passed++;
        end
        total++;
        if (LCD_EN !== 1'b0 || LCD_RS !== 1'b0 || LCD_DATA !== 8'h00 || oBUSY !== 1'b0 || LCD_RW !== 1'b0)
            $display("FAIL reset_values got en=%b rs=%b data=%h busy=%b rw=%b exp all zero",
                     LCD_EN, LCD_RS, LCD_DATA, oBUSY, LCD_RW);
        else passed++;
        push_exp(1, 1'b1, 8'h55);
        iRST   = 1'b0;
        c      = cyc;
        mon_en = 1'b1;
        wait_ack(10, p, t);
        total++;
        if (p != 1 || t != c + 1) $display("FAIL post_reset_ack got port=%0d cyc=%0d exp port=1 cyc=%0d", p, t, c + 1);
        else passed++;
        iREQ1 = 1'b0;
        wait_idle(SHORT_PER + 10, ok);
        total++;
        if (!ok) $display("FAIL reset_idle got busy=1 exp idle within budget");
        else passed++;
    endtask

    task automatic test_single_write();
        int c, p, t1, p2, t2, en_first, en_cnt, busy_cnt, n;
        bit ok;
        iREQ0  = 1'b1;
        iRS0   = 1'b0;
        iDATA0 = 8'h38;
        push_exp(0, 1'b0, 8'h38);
        push_exp(0, 1'b0, 8'h38);
        c = cyc;
        wait_ack(10, p, t1);
        total++;
        if (p != 0 || t1 != c + 1) $display("FAIL single_ack got port=%0d cyc=%0d exp port=0 cyc=%0d", p, t1, c + 1);
        else passed++;
        en_first = -1;
        en_cnt   = 0;
        busy_cnt = oBUSY ? 1 : 0;
        p2 = -1;
        t2 = -1;
        n  = 0;
        while (p2 < 0 && n < SHORT_PER + 20) begin
            @(negedge iCLK);
            n++;
            if (oACK0 || oACK1) begin
                p2 = oACK0 ? 0 : 1;
                t2 = cyc;
            end else begin
                if (LCD_EN) begin
                    if (en_first < 0) en_first = cyc;
                    en_cnt++;
                end
                if (oBUSY) busy_cnt++;
            end
        end
        iREQ0 = 1'b0;
        total++;
        if (en_first != t1 + SETUP_C) $display("FAIL en_start got=%0d exp=%0d", en_first, t1 + SETUP_C);
        else passed++;
        total++;
        if (en_cnt != EN_C) $display("FAIL en_width got=%0d exp=%0d", en_cnt, EN_C);
        else passed++;
        total++;
        if (busy_cnt != SHORT_PER - 1) $display("FAIL busy_width got=%0d exp=%0d", busy_cnt, SHORT_PER - 1);
        else passed++;
        total++;
        if (p2 != 0 || t2 - t1 != SHORT_PER) $display("FAIL held_reack got port=%0d period=%0d exp port=0 period=%0d", p2, t2 - t1, SHORT_PER);
        else passed++;
        wait_idle(SHORT_PER + 10, ok);
        total++;
        if (!ok) $display("FAIL single_idle got busy=1 exp idle within budget");
        else passed++;
    endtask

    task automatic test_round_robin();
        int c, p, t, prev_t;
        bit ok;
        @(negedge iCLK);
        iRST   = 1'b1;
        iREQ0  = 1'b1;
        iRS0   = 1'b0;
        iDATA0 = 8'h30;
        iREQ1  = 1'b1;
        iRS1   = 1'b1;
        iDATA1 = 8'hC1;
        repeat (2) @(negedge iCLK);
        push_exp(0, 1'b0, 8'h30);
        push_exp(1, 1'b1, 8'hC1);
        push_exp(0, 1'b0, 8'h30);
        push_exp(1, 1'b1, 8'hC1);
        iRST   = 1'b0;
        c      = cyc;
        prev_t = c;
        for (int k = 0; k < 4; k++) begin
            wait_ack(SHORT_PER + 10, p, t);
            total++;
            if (p != (k % 2) || t - prev_t != ((k == 0) ? 1 : SHORT_PER))
                $display("FAIL rr_ack%0d got port=%0d delta=%0d exp port=%0d delta=%0d",
                         k, p, t - prev_t, k % 2, (k == 0) ? 1 : SHORT_PER);
            else passed++;
            prev_t = t;
        end
        iREQ0 = 1'b0;
        iREQ1 = 1'b0;
        wait_idle(SHORT_PER + 10, ok);
        total++;
        if (!ok) $display("FAIL rr_idle got busy=1 exp idle within budget");
        else passed++;
    endtask

    logic [7:0] lw_data [0:4] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    logic       lw_rs   [0:4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit         lw_long [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic test_long_wait();
        int p, t1, t2, exp_per;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            iREQ1  = 1'b1;
            iRS1   = lw_rs[i];
            iDATA1 = lw_data[i];
            push_exp(1, lw_rs[i], lw_data[i]);
            wait_ack(10, p, t1);
            total++;
            if (p != 1) $display("FAIL lw_first%0d got port=%0d exp port=1", i, p);
            else passed++;
            iRS1   = 1'b1;
            iDATA1 = 8'h20 + 8'(i);
            push_exp(1, 1'b1, 8'h20 + 8'(i));
            exp_per = lw_long[i] ? LONG_PER : SHORT_PER;
            wait_ack(LONG_PER + 20, p, t2);
            iREQ1 = 1'b0;
            total++;
            if (p != 1 || t2 - t1 != exp_per)
                $display("FAIL lw_period%0d rs=%b data=%h got port=%0d period=%0d exp port=1 period=%0d",
                         i, lw_rs[i], lw_data[i], p, t2 - t1, exp_per);
            else passed++;
            wait_idle(SHORT_PER + 10, ok);
            total++;
            if (!ok) $display("FAIL lw_idle%0d got busy=1 exp idle within budget", i);
            else passed++;
        end
    endtask

    task automatic test_reset_midwrite();
        int c, p, t, n;
        bit ok, seen;
        iREQ0  = 1'b1;
        iRS0   = 1'b1;
        iDATA0 = 8'hA5;
        push_exp(0, 1'b1, 8'hA5);
        push_exp(0, 1'b1, 8'hA5);
        wait_ack(10, p, t);
        total++;
        if (p != 0) $display("FAIL mid_first got port=%0d exp port=0", p);
        else passed++;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge iCLK);
            n++;
            if (LCD_EN) seen = 1'b1;
        end
        total++;
        if (!seen) $display("FAIL mid_en_seen got en=0 exp en=1 within budget");
        else passed++;
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        total++;
        if (LCD_EN !== 1'b0 || oBUSY !== 1'b0 || LCD_DATA !== 8'h00 || LCD_RS !== 1'b0 || oACK0 !== 1'b0 || oACK1 !== 1'b0)
            $display("FAIL mid_reset got en=%b busy=%b data=%h rs=%b ack0=%b ack1=%b exp all zero",
                     LCD_EN, oBUSY, LCD_DATA, LCD_RS, oACK0, oACK1);
        else passed++;
        iRST = 1'b0;
        c    = cyc;
        wait_ack(10, p, t);
        iREQ0 = 1'b0;
        total++;
        if (p != 0 || t != c + 1) $display("FAIL mid_reack got port=%0d cyc=%0d exp port=0 cyc=%0d", p, t, c + 1);
        else passed++;
        wait_idle(SHORT_PER + 10, ok);
        total++;
        if (!ok) $display("FAIL mid_idle got busy=1 exp idle within budget");
        else passed++;
    endtask

    task automatic test_wait_request();
        int p, t1, t2, idle_first, n;
        iREQ0  = 1'b1;
        iRS0   = 1'b1;
        iDATA0 = 8'h41;
        push_exp(0, 1'b1, 8'h41);
        wait_ack(10, p, t1);
        iREQ0 = 1'b0;
        total++;
        if (p != 0) $display("FAIL wr_first got port=%0d exp port=0", p);
        else passed++;
        repeat (100) @(negedge iCLK);
        iREQ1  = 1'b1;
        iRS1   = 1'b1;
        iDATA1 = 8'h42;
        push_exp(1, 1'b1, 8'h42);
        idle_first = -1;
        p  = -1;
        t2 = -1;
        n  = 0;
        while (p < 0 && n < SHORT_PER + 20) begin
            @(negedge iCLK);
            n++;
            if (oACK0 || oACK1) begin
                p  = oACK0 ? 0 : 1;
                t2 = cyc;
            end else if (!oBUSY && idle_first < 0) begin
                idle_first = cyc;
            end
        end
        iREQ1 = 1'b0;
        total++;
        if (idle_first != t1 + SHORT_PER - 1) $display("FAIL wr_idle_cycle got=%0d exp=%0d", idle_first, t1 + SHORT_PER - 1);
        else passed++;
        total++;
        if (p != 1 || t2 != t1 + SHORT_PER) $display("FAIL wr_ack got port=%0d cyc=%0d exp port=1 cyc=%0d", p, t2, t1 + SHORT_PER);
        else passed++;
    endtask

    initial begin
        bit ok;
        test_reset();
        test_single_write();
        test_round_robin();
        test_long_wait();
        test_reset_midwrite();
        test_wait_request();
        wait_idle(SHORT_PER + 10, ok);
        repeat (3) @(negedge iCLK);
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
